// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with hold timeout, registered
// contention flags (one/two/all) and a wrapping grant counter.
// All outputs come straight from flops.
module rr_arbiter3 #(
  parameter int unsigned HOLD_MAX = 8,  // 1..255
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       req_i,
  input  logic             release_i,
  output logic [2:0]       grant_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             one_o,
  output logic             two_o,
  output logic             all_o,
  output logic [CNT_W-1:0] grant_count_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             one_q, two_q, all_q;

  logic [2:0] win;
  logic [1:0] ptr_after;
  logic [1:0] req_pop;
  logic       owner_req, end_norm, expire;

  // First set request scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    win = 3'b000;
    case (ptr_q)
      2'd1:    if (req_i[1]) win = 3'b010; else if (req_i[2]) win = 3'b100;
               else if (req_i[0]) win = 3'b001;
      2'd2:    if (req_i[2]) win = 3'b100; else if (req_i[0]) win = 3'b001;
               else if (req_i[1]) win = 3'b010;
      default: if (req_i[0]) win = 3'b001; else if (req_i[1]) win = 3'b010;
               else if (req_i[2]) win = 3'b100;
    endcase
  end

  // Pointer moves to the requester just after the current owner.
  always_comb begin
    ptr_after = 2'd0;
    case (grant_q)
      3'b001:  ptr_after = 2'd1;
      3'b010:  ptr_after = 2'd2;
      default: ptr_after = 2'd0;
    endcase
  end

  assign owner_req = |(req_i & grant_q);
  assign end_norm  = release_i | ~owner_req;
  assign expire    = (hold_q == HOLD_LAST);
  assign req_pop   = {1'b0, req_i[0]} + {1'b0, req_i[1]} + {1'b0, req_i[2]};

  // Next-state: grant from IDLE, end or extend the grant in GRANT.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = win;
          hold_d  = 8'd0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (end_norm || expire) begin
          grant_d   = 3'b000;
          ptr_d     = ptr_after;
          state_d   = IDLE;
          // A coincident release or drop wins over the timeout.
          timeout_d = expire & ~end_norm;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      one_q     <= 1'b0;
      two_q     <= 1'b0;
      all_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      one_q     <= (req_pop == 2'd1);
      two_q     <= (req_pop == 2'd2);
      all_q     <= (req_pop == 2'd3);
    end
  end

  assign grant_o       = grant_q;
  assign busy_o        = (state_q == GRANT);
  assign timeout_o     = timeout_q;
  assign one_o         = one_q;
  assign two_o         = two_q;
  assign all_o         = all_q;
  assign grant_count_o = cnt_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Bench for rr_arbiter3: two instances (HOLD_MAX=8/CNT_W=8 and
// HOLD_MAX=1/CNT_W=2) share stimulus; a behavioural model is compared
// every cycle and directed steps pin literal expectations.
module tb_rr_arbiter3;

  logic       clock, reset, release_i;
  logic [2:0] req;
  logic [2:0] ga, gb;
  logic       busy_a, to_a, one_a, two_a, all_a;
  logic       busy_b, to_b, one_b, two_b, all_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_chk = 0, n_pass = 0;
  bit chk_on = 0;

  rr_arbiter3 #(.HOLD_MAX(8), .CNT_W(8)) ua (
    .clock(clock), .reset(reset), .req_i(req), .release_i(release_i),
    .grant_o(ga), .busy_o(busy_a), .timeout_o(to_a), .one_o(one_a),
    .two_o(two_a), .all_o(all_a), .grant_count_o(cnt_a));

  rr_arbiter3 #(.HOLD_MAX(1), .CNT_W(2)) ub (
    .clock(clock), .reset(reset), .req_i(req), .release_i(release_i),
    .grant_o(gb), .busy_o(busy_b), .timeout_o(to_b), .one_o(one_b),
    .two_o(two_b), .all_o(all_b), .grant_count_o(cnt_b));

  initial clock = 0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int HM[2] = '{8, 1};
  int CW[2] = '{8, 2};
  int m_own[2] = '{-1, -1};   // owner index, -1 when nobody holds the grant
  int m_ptr[2] = '{0, 0};
  int m_hold[2] = '{0, 0};    // cycles the current owner has held so far minus one
  int m_cnt[2] = '{0, 0};
  bit m_to[2] = '{0, 0};
  int m_pc = 0;               // number of requests seen at the last edge

  task automatic mstep(int k);
    bit norm, exp_t;
    m_to[k] = 0;
    if (m_own[k] < 0) begin
      for (int i = 0; i < 3; i++) begin
        int j = (m_ptr[k] + i) % 3;
        if (req[j] && m_own[k] < 0) begin
          m_own[k] = j;
          m_hold[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % (1 << CW[k]);
        end
      end
    end else begin
      norm  = release_i || !req[m_own[k]];
      exp_t = (m_hold[k] == HM[k] - 1);
      if (norm || exp_t) begin
        m_to[k]  = exp_t && !norm;
        m_ptr[k] = (m_own[k] + 1) % 3;
        m_own[k] = -1;
      end else m_hold[k]++;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0; m_cnt[k] = 0; m_to[k] = 0;
      end
      m_pc = 0;
    end else begin
      m_pc = $countones(req);
      for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  function automatic logic [15:0] mexp(int k);
    logic [2:0] g;
    g = (m_own[k] < 0) ? 3'b000 : 3'(1 << m_own[k]);
    return {g, m_own[k] >= 0, m_to[k], m_pc == 1, m_pc == 2, m_pc == 3, 8'(m_cnt[k])};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    else n_pass++;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(posedge clock) begin
    #1;
    if (chk_on) begin
      chk("model_a", {ga, busy_a, to_a, one_a, two_a, all_a, cnt_a}, mexp(0));
      chk("model_b", {gb, busy_b, to_b, one_b, two_b, all_b, 6'b0, cnt_b}, mexp(1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [2:0] r, input logic rel);
    req = r; release_i = rel;
    @(posedge clock); #2;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1; #3; reset = 0;
  endtask

  initial begin
    reset = 1; req = 3'b000; release_i = 0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_grant", ga, 3'b000);
    chk("rst_flags", {busy_a, to_a, one_a, two_a, all_a}, 5'b0);
    chk("rst_cnt", cnt_a, 8'd0);
    reset = 0; chk_on = 1;

    // single requester 1
    cyc(3'b010, 0);
    chk("t1_grant", ga, 3'b010);
    chk("t1_busy_cnt", {busy_a, cnt_a}, {1'b1, 8'd1});
    chk("t1_class", {one_a, two_a, all_a}, 3'b100);

    // rotation with all three requesting, plus CNT_W=2 wrap on ub
    do_reset();
    cyc(3'b111, 0); chk("rr_g1", ga, 3'b001); chk("rr_all", all_a, 1'b1); chk("b_cnt1", cnt_b, 2'd1);
    cyc(3'b111, 1); chk("rr_gap1", ga, 3'b000);
    cyc(3'b111, 0); chk("rr_g2", ga, 3'b010); chk("b_cnt2", cnt_b, 2'd2);
    cyc(3'b111, 1); chk("rr_gap2", ga, 3'b000);
    cyc(3'b111, 0); chk("rr_g3", ga, 3'b100); chk("b_cnt3", cnt_b, 2'd3);
    cyc(3'b111, 1); chk("rr_gap3", ga, 3'b000);
    cyc(3'b111, 0); chk("rr_g4", ga, 3'b001); chk("rr_cnt4", cnt_a, 8'd4); chk("b_cnt4", cnt_b, 2'd0);
    cyc(3'b111, 1);
    cyc(3'b100, 0); chk("g5", ga, 3'b100); chk("cnt5", cnt_a, 8'd5); chk("b_cnt5", cnt_b, 2'd1);

    // asynchronous reset mid-grant
    reset = 1; #1;
    chk("async_rst", {ga, busy_a, cnt_a}, 12'h000);
    #1 reset = 0;
    cyc(3'b000, 1); chk("rel_idle", {ga, busy_a, cnt_a}, 12'h000);
    cyc(3'b110, 0); chk("post_rst_g", ga, 3'b010); chk("two", {one_a, two_a, all_a}, 3'b010);

    // hold timeout, sole requester 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(3'b001, 0);
      chk("hold_g", ga, 3'b001);
      if (i == 0) chk("b_g", gb, 3'b001);
      if (i == 1) chk("b_to", {gb, to_b}, 4'b0001);
    end
    cyc(3'b001, 0); chk("to_pulse", {ga, busy_a, to_a}, 5'b00001);
    cyc(3'b001, 0); chk("to_regrant", {ga, to_a}, 4'b0010);

    // owner drops on the expiry edge: normal end, ptr -> 1
    do_reset();
    cyc(3'b001, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(3'b001, 0);
      chk("drop_hold", ga, 3'b001);
    end
    cyc(3'b000, 0); chk("drop_end", {ga, to_a}, 4'b0000);
    cyc(3'b101, 0); chk("drop_next", ga, 3'b100);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 150; i++)
      cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
